sram_access_ctrl: RTL and testbench

SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

---
 rtl/sram_pkg.sv | 14 +
 rtl/phase_timer.sv | 33 +++
 rtl/sram_access_ctrl.sv | 124 ++++++++++++
 tb/tb_sram_access_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and geometry for the 8-word SRAM array, decoder and controller
package sram_pkg;

  localparam int ADDR_W = 3;
  localparam int WORDS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_WL   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - 4-bit load/count-down timer; done while the count sits at zero
module phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - sequences precharge, word-line and sense phases for one array access at a time
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRE_CYC = 2,
  parameter int SEN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              wl_valid,
  output logic              precharge,
  output logic              write_en,
  output logic [DATA_W-1:0] bl_data,
  output logic              sense_en,
  input  logic [DATA_W-1:0] sense_data
);

  // The timer counts N-1 down to 0, so each phase lasts exactly N cycles.
  localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC - 1);
  localparam logic [3:0] SEN_LOAD = 4'(SEN_CYC - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                tmr_load;
  logic [3:0]          tmr_val;
  logic                tmr_en;
  logic                tmr_done;
  logic                accept;

  phase_timer u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = 4'd0;
    tmr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d  = ST_PRE;
          tmr_load = 1'b1;
          tmr_val  = PRE_LOAD;
        end
      end
      ST_PRE: begin
        if (tmr_done) begin
          state_d  = ST_WL;
          tmr_load = 1'b1;
          tmr_val  = SEN_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_WL: begin
        if (tmr_done) begin
          state_d = ST_RESP;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        wr_q    <= req_write;
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end else if (sense_en) begin
        rdata_q <= sense_data;
      end
    end
  end

  // Array controls decode straight from state so an async reset drops them at once.
  assign req_ready = (state_q == ST_IDLE);
  assign precharge = (state_q == ST_PRE);
  assign wl_valid  = (state_q == ST_WL);
  assign write_en  = wl_valid && wr_q;
  assign bl_data   = write_en ? wdata_q : '0;
  assign sense_en  = wl_valid && !wr_q && tmr_done;
  assign addr      = (state_q == ST_IDLE) ? '0 : addr_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - table-driven bench for sram_access_ctrl
module tb_sram_access_ctrl;

  localparam int PRE = 2;
  localparam int SEN = 2;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic [2:0] addr;
  logic       wl_valid;
  logic       precharge;
  logic       write_en;
  logic [7:0] bl_data;
  logic       sense_en;
  logic [7:0] sense_data;

  sram_access_ctrl #(.DATA_W(8), .PRE_CYC(PRE), .SEN_CYC(SEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .addr       (addr),
    .wl_valid   (wl_valid),
    .precharge  (precharge),
    .write_en   (write_en),
    .bl_data    (bl_data),
    .sense_en   (sense_en),
    .sense_data (sense_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pre;
    logic       wl;
    logic       we;
    logic       sen;
    logic       rv;
    logic       rr;
    logic [2:0] addr;
    logic [7:0] bl;
    logic [7:0] rd;
  } obs_t;

  typedef struct {
    logic       write;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] sense;
    logic [7:0] exp_rdata;
    int         hold;
  } vec_t;

  vec_t vecs[5];
  int   checks;
  int   failures;

  function automatic obs_t sample();
    obs_t o;
    o.pre  = precharge;
    o.wl   = wl_valid;
    o.we   = write_en;
    o.sen  = sense_en;
    o.rv   = rsp_valid;
    o.rr   = req_ready;
    o.addr = addr;
    o.bl   = bl_data;
    o.rd   = rsp_rdata;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.rr = 1'b1;
    return o;
  endfunction

  // Expected outputs in cycle k after the request handshake (k = PRE+SEN+1 is RESP).
  function automatic obs_t exp_obs(vec_t v, int k);
    obs_t o;
    o = '0;
    o.addr = v.addr;
    if (k <= PRE) begin
      o.pre = 1'b1;
    end else if (k <= PRE + SEN) begin
      o.wl  = 1'b1;
      o.we  = v.write;
      o.bl  = v.write ? v.wdata : 8'h00;
      o.sen = (k == PRE + SEN) && !v.write;
    end else begin
      o.rv = 1'b1;
      o.rd = v.exp_rdata;
    end
    return o;
  endfunction

  task automatic chk(string nm, int idx, obs_t act, obs_t exp, bit cmp_rd);
    if (!cmp_rd) begin
      act.rd = '0;
      exp.rd = '0;
    end
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h required=%h (pre,wl,we,sen,rv,rr,addr,bl,rd)",
               nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(int i);
    vec_t v;
    v = vecs[i];
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    rsp_ready = 1'b0;
    chk("idle_before_req", i, sample(), idle_obs(), 1'b0);
    tick();
    req_valid = 1'b0;
    req_wdata = 8'h00;
    for (int k = 1; k <= PRE + SEN; k++) begin
      sense_data = (k == PRE + SEN) ? v.sense : ~v.sense;
      chk($sformatf("phase_k%0d", k), i, sample(), exp_obs(v, k), 1'b0);
      checks++;
      if (precharge && wl_valid) begin
        failures++;
        $display("FAIL overlap vec=%0d actual=1 required=0", i);
      end
      tick();
    end
    // Competing request during RESP must not be taken, even in the handshake cycle.
    req_valid = 1'b1;
    req_addr  = 3'd6;
    req_write = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      sense_data = 8'($urandom);
      chk($sformatf("resp_hold%0d", h), i, sample(), exp_obs(v, PRE + SEN + 1), 1'b1);
      tick();
    end
    sense_data = 8'($urandom);
    rsp_ready  = 1'b1;
    chk("resp_handshake", i, sample(), exp_obs(v, PRE + SEN + 1), 1'b1);
    tick();
    rsp_ready = 1'b0;
    chk("idle_after_rsp", i, sample(), idle_obs(), 1'b0);
  endtask

  initial begin
    obs_t o;
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 3'd0;
    req_wdata  = 8'h00;
    rsp_ready  = 1'b0;
    sense_data = 8'h00;

    vecs[0] = '{write: 1'b1, addr: 3'd5, wdata: 8'hA5, sense: 8'h11, exp_rdata: 8'h00, hold: 0};
    vecs[1] = '{write: 1'b0, addr: 3'd3, wdata: 8'h00, sense: 8'h3C, exp_rdata: 8'h3C, hold: 4};
    vecs[2] = '{write: 1'b0, addr: 3'd0, wdata: 8'h00, sense: 8'h81, exp_rdata: 8'h81, hold: 0};
    vecs[3] = '{write: 1'b1, addr: 3'd7, wdata: 8'hFF, sense: 8'h42, exp_rdata: 8'h00, hold: 1};
    vecs[4] = '{write: 1'b0, addr: 3'd7, wdata: 8'h00, sense: 8'h5A, exp_rdata: 8'h5A, hold: 2};

    #12;
    chk("reset_state", 0, sample(), idle_obs(), 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", 0, sample(), idle_obs(), 1'b1);

    for (int i = 0; i < 5; i++) begin
      do_access(i);
    end
    req_valid = 1'b0;
    tick();
    chk("idle_quiet", 0, sample(), idle_obs(), 1'b0);

    // Abort a write in its first WL cycle with an asynchronous reset.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 3'd2;
    req_wdata = 8'hC3;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= PRE; k++) tick();
    o = '0;
    o.wl = 1'b1; o.we = 1'b1; o.addr = 3'd2; o.bl = 8'hC3;
    chk("abort_in_wl", 9, sample(), o, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_immediate", 9, sample(), idle_obs(), 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("abort_ready_after_release", 9, sample(), idle_obs(), 1'b1);

    do_access(1);
    req_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
